// File: rtl/mqam_pkg.sv
// Shared constants for the M-QAM modulator: mode encoding, bits-per-symbol lookup,
// Gray level values and scrambler LFSR parameters.
package mqam_pkg;

    localparam logic [1:0] MODE_QPSK  = 2'd0;
    localparam logic [1:0] MODE_16QAM = 2'd1;
    localparam logic [1:0] MODE_64QAM = 2'd2;

    localparam int MAX_BPS = 6;

    localparam logic signed [3:0] LVL_P1 = 4'sd1;
    localparam logic signed [3:0] LVL_M1 = -4'sd1;
    localparam logic signed [3:0] LVL_P3 = 4'sd3;
    localparam logic signed [3:0] LVL_M3 = -4'sd3;
    localparam logic signed [3:0] LVL_P5 = 4'sd5;
    localparam logic signed [3:0] LVL_M5 = -4'sd5;
    localparam logic signed [3:0] LVL_P7 = 4'sd7;
    localparam logic signed [3:0] LVL_M7 = -4'sd7;

    // x^7 + x^4 + 1: feedback taken from s[6] ^ s[3]
    localparam logic [6:0] LFSR_SEED  = 7'h7F;
    localparam int         LFSR_TAP_A = 6;
    localparam int         LFSR_TAP_B = 3;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } collect_state_t;

    // Mode 3 is reserved and behaves as 16QAM.
    function automatic logic [2:0] bps_of(input logic [1:0] m);
        case (m)
            MODE_QPSK:  return 3'd2;
            MODE_64QAM: return 3'd6;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mqam_gray_map.sv
// Combinational Gray mapper: collected symbol bits (right-justified, first bit highest)
// to signed I/Q levels for the latched modulation mode.
module mqam_gray_map
    import mqam_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [1:0]               mode,
    input  logic [MAX_BPS-1:0]       bits,
    output logic signed [DATA_W-1:0] lvl_i,
    output logic signed [DATA_W-1:0] lvl_q
);

    function automatic logic signed [3:0] gray1(input logic g);
        return g ? LVL_M1 : LVL_P1;
    endfunction

    function automatic logic signed [3:0] gray2(input logic [1:0] g);
        case (g)
            2'b00:   return LVL_M3;
            2'b01:   return LVL_M1;
            2'b11:   return LVL_P1;
            default: return LVL_P3;
        endcase
    endfunction

    function automatic logic signed [3:0] gray3(input logic [2:0] g);
        case (g)
            3'b000:  return LVL_M7;
            3'b001:  return LVL_M5;
            3'b011:  return LVL_M3;
            3'b010:  return LVL_M1;
            3'b110:  return LVL_P1;
            3'b111:  return LVL_P3;
            3'b101:  return LVL_P5;
            default: return LVL_P7;
        endcase
    endfunction

    logic signed [3:0] li;
    logic signed [3:0] lq;

    always_comb begin
        li = gray2(bits[3:2]);
        lq = gray2(bits[1:0]);
        case (mode)
            MODE_QPSK: begin
                li = gray1(bits[1]);
                lq = gray1(bits[0]);
            end
            MODE_64QAM: begin
                li = gray3(bits[5:3]);
                lq = gray3(bits[2:0]);
            end
            default: ;
        endcase
    end

    assign lvl_i = DATA_W'(li);
    assign lvl_q = DATA_W'(lq);

endmodule

// File: rtl/mqam_mod.sv
// Run-time selectable QPSK/16QAM/64QAM modulator: bit collection, Gray mapping,
// zero-stuffed upsampling and carrier mixing. Define QAM_SCRAMBLER_EN to scramble input bits.
module mqam_mod
    import mqam_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int FLT_W  = 19,
    parameter int CAR_W  = 10,
    parameter int OSR    = 8
) (
    input  logic                          CLK,
    input  logic                          Rst,
    input  logic [1:0]                    mode,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          bit_ready,
    output logic signed [DATA_W-1:0]      up_i,
    output logic signed [DATA_W-1:0]      up_q,
    output logic                          sym_stb,
    output logic                          underrun,
    input  logic signed [FLT_W-1:0]       fi,
    input  logic signed [FLT_W-1:0]       fq,
    input  logic signed [CAR_W-1:0]       sin_in,
    input  logic signed [CAR_W-1:0]       cos_in,
    output logic signed [FLT_W+CAR_W-1:0] mult_i,
    output logic signed [FLT_W+CAR_W-1:0] mult_q,
    output logic signed [FLT_W+CAR_W:0]   dout
);

    localparam int               CNT_W    = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
    localparam int               MULT_W   = FLT_W + CAR_W;

    collect_state_t     state_reg, state_next;
    logic [MAX_BPS-1:0] sbuf_reg, sbuf_next;
    logic [2:0]         bcnt_reg, bcnt_next;
    logic [1:0]         mode_reg;
    logic [1:0]         mode_eff;
    logic [CNT_W-1:0]   cnt_reg;
    logic               boundary;
    logic               accept;
    logic               bit_data;
    logic signed [DATA_W-1:0] map_i, map_q;

    assign boundary  = (cnt_reg == CNT_LAST);
    assign bit_ready = (state_reg == ST_COLLECT);
    assign accept    = bit_valid && bit_ready;
    // The first bit of a symbol is sized by the live mode, which is latched on that same edge.
    assign mode_eff  = (bcnt_reg == 3'd0) ? mode : mode_reg;

`ifdef QAM_SCRAMBLER_EN
    logic [6:0] lfsr_reg;
    logic       lfsr_fb;

    assign lfsr_fb  = lfsr_reg[LFSR_TAP_A] ^ lfsr_reg[LFSR_TAP_B];
    assign bit_data = bit_in ^ lfsr_fb;

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst)
            lfsr_reg <= LFSR_SEED;
        else if (accept)
            lfsr_reg <= {lfsr_reg[5:0], lfsr_fb};
    end
`else
    assign bit_data = bit_in;
`endif

    always_comb begin
        state_next = state_reg;
        sbuf_next  = sbuf_reg;
        bcnt_next  = bcnt_reg;
        case (state_reg)
            ST_COLLECT: begin
                if (accept) begin
                    sbuf_next = {sbuf_reg[MAX_BPS-2:0], bit_data};
                    bcnt_next = bcnt_reg + 3'd1;
                    if (bcnt_reg + 3'd1 == bps_of(mode_eff))
                        state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (boundary) begin
                    sbuf_next  = '0;
                    bcnt_next  = '0;
                    state_next = ST_COLLECT;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state_reg <= ST_COLLECT;
            sbuf_reg  <= '0;
            bcnt_reg  <= '0;
            mode_reg  <= MODE_QPSK;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sbuf_reg  <= sbuf_next;
            bcnt_reg  <= bcnt_next;
            if (bcnt_reg == 3'd0)
                mode_reg <= mode;
            cnt_reg   <= boundary ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    mqam_gray_map #(
        .DATA_W(DATA_W)
    ) u_gray_map (
        .mode  (mode_reg),
        .bits  (sbuf_reg),
        .lvl_i (map_i),
        .lvl_q (map_q)
    );

    // Zero-stuffed output: one non-zero sample per symbol period, else zero.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            up_i     <= '0;
            up_q     <= '0;
            sym_stb  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            up_i     <= '0;
            up_q     <= '0;
            sym_stb  <= 1'b0;
            underrun <= 1'b0;
            if (boundary) begin
                if (state_reg == ST_FULL) begin
                    up_i    <= map_i;
                    up_q    <= map_q;
                    sym_stb <= 1'b1;
                end else begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            mult_i <= '0;
            mult_q <= '0;
            dout   <= '0;
        end else begin
            mult_i <= fi * sin_in;
            mult_q <= fq * cos_in;
            dout   <= (MULT_W + 1)'(mult_i) + (MULT_W + 1)'(mult_q);
        end
    end

endmodule

// File: doc/mqam_mod.md
# mqam_mod

Run-time-selectable M-QAM modulator core (QPSK / 16QAM / 64QAM), the parametrised successor to the fixed 16QAM transmit top. It sits between the bit source and the DAC path. It has five functions: accept a serial bit stream over a valid/ready handshake, Gray-map it to I/Q levels, zero-stuff to OSR samples per symbol for an external interpolation FIR, take the filtered I/Q back, and mix them with an externally supplied carrier into a registered passband sum.

## Interface
- DATA_W, 4: signed width of mapped/upsampled I/Q levels (≥4, must hold ±7)
- FLT_W, 19: signed width of filtered I/Q returned from the FIR
- CAR_W, 10: signed width of carrier sin/cos
- OSR, 8: samples per symbol (≥2)
- CLK  in  1  clock; reset Rst, asynchronous, active-high; clock CLK
- Rst  in  1  asynchronous active-high reset
- mode  in  2  0=QPSK, 1=16QAM, 2=64QAM, 3=treated as 16QAM
- bit_in  in  1  serial data bit
- bit_valid  in  1  bit_in valid
- bit_ready  out  1  block can accept a bit
- up_i, up_q  out  DATA_W  zero-stuffed symbol levels to FIR
- sym_stb  out  1  one-cycle pulse aligned with non-zero up_i/up_q
- underrun  out  1  one-cycle pulse: symbol boundary with incomplete buffer
- fi, fq  in  FLT_W  filtered I/Q from FIR
- sin_in, cos_in  in  CAR_W  carrier samples
- mult_i, mult_q  out  FLT_W+CAR_W  registered fi·sin_in, fq·cos_in
- dout  out  FLT_W+CAR_W+1  registered mult_i+mult_q

## Operation
- BPS = 2/4/6 for mode 0/1/2(3→4). mode is latched when the collect buffer is empty. A mode change during collection takes effect at the next symbol.
- Collect FSM, two states:
  - COLLECT: bit_ready=1. Each bit_valid&&bit_ready shifts a bit in MSB-first and increments bcnt. When bcnt reaches BPS, go to FULL.
  - FULL: bit_ready=0. Wait for the symbol boundary, then clear the buffer and bcnt and return to COLLECT.
- Sample counter cnt counts 0..OSR-1 free-running and wraps. The edge where cnt==OSR-1 is the symbol boundary:
  - If FULL: up_i/up_q ← mapped levels, sym_stb←1.
  - Otherwise: up_i/up_q←0, underrun←1, and any partial buffer is kept.
  - On all other edges, up_i/up_q/sym_stb/underrun←0.
- Bit split: the first BPS/2 bits map to I, the remainder to Q. Gray levels per axis:
  - 1 bit: 0→+1, 1→−1
  - 2 bits: 00→−3, 01→−1, 11→+1, 10→+3
  - 3 bits: 000→−7, 001→−5, 011→−3, 010→−1, 110→+1, 111→+3, 101→+5, 100→+7
- Levels are sign-extended to DATA_W.
- Mixer: mult_i←fi·sin_in and mult_q←fq·cos_in, both full-precision signed. dout←mult_i+mult_q with one growth bit, so no saturation is needed.

## Timing
- Reset values: all outputs 0 except bit_ready=1. cnt=0, FSM=COLLECT, bcnt=0.
- First symbol boundary is the OSR-th rising edge after reset release.
- Bit to output: a symbol completed by cycle t appears on up_i at the next boundary edge. This is up to OSR cycles later.
- Boundary and FULL clear happen on the same edge. bit_ready rises the cycle after, so no bit is lost or double-counted.
- Mixer latency: 1 cycle from fi/sin_in to mult_i; 2 cycles to dout.
- Rst mid-operation clears the partial buffer, the counters and the pipeline immediately (async). No stale bits survive.

## Configuration
- QAM_SCRAMBLER_EN defined: accepted bits are XORed with s[6]^s[3] of a 7-bit LFSR (x^7+x^4+1).
  - Seed is 7'h7F, reloaded on Rst.
  - The LFSR advances only on an accepted bit.
- Not defined: bits enter the buffer unmodified and no LFSR is instantiated.

## Structure
- Package mqam_pkg holds:
  - mode encoding constants
  - the BPS lookup function
  - Gray level constants (±1, ±3, ±5, ±7)
  - LFSR seed and taps
- One sub-module, mqam_gray_map: combinational (mode, buffer) → (I, Q) levels. Instantiated once.
- FSM, counters, scrambler and mixer pipeline stay in mqam_mod.

## Test plan
- QPSK, OSR=8, bits 0,0: at first boundary up_i=+1, up_q=+1, sym_stb=1. The other 7 cycles are 0.
- 16QAM, bits 1,0,0,1: up_i=+3, up_q=−1. bit_ready stays low from the 4th accepted bit until the boundary edge.
- 64QAM, bits 1,0,0,0,0,0: up_i=+7, up_q=−7. mode switched to QPSK mid-symbol is ignored until the next symbol.
- No bit_valid for 3 symbol periods: up_i=up_q=0, sym_stb=0, underrun pulses every 8 cycles.
- fi=100, sin_in=−200, fq=−50, cos_in=300: next cycle mult_i=−20000 and mult_q=−15000. The cycle after, dout=−35000.
- 16QAM, 2 bits accepted then Rst pulse: all outputs 0, bit_ready=1. 4 new bits are required before the next sym_stb. With QAM_SCRAMBLER_EN, the LFSR is back at 7'h7F.
